// File: rtl/trace_buffer_pkg.sv
// Shared types and width helpers for the trace FIFO and its storage array.
package trace_buffer_pkg;

    typedef enum logic {
        OVF_DROP_NEW      = 1'b0,
        OVF_OVERWRITE_OLD = 1'b1
    } overflow_mode_e;

    localparam int unsigned TRACE_DATA_WIDTH = 64;

    typedef logic [TRACE_DATA_WIDTH-1:0] trace_elem_t;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // One extra bit so that DEPTH (full) and 0 (empty) are distinct.
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/trace_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one write port, one asynchronous read port.
module trace_fifo_mem
    import trace_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AW         = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/trace_fifo.sv
// Trace element FIFO with show-ahead output, flush, selectable overflow policy
// and a saturating lost-element counter.
module trace_fifo
    import trace_buffer_pkg::*;
#(
    parameter int unsigned    DATA_WIDTH    = 64,
    parameter int unsigned    DEPTH         = 8,
    parameter overflow_mode_e OVERFLOW_MODE = OVF_DROP_NEW,
    parameter int unsigned    AF_THRESH     = DEPTH - 2,
    parameter int unsigned    OVF_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    input  logic                       flush,
    input  logic                       clr_ovf,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       almost_full,
    output logic [OVF_CNT_WIDTH-1:0]   overflow_count,
    output logic                       ovf_pulse
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned LW = level_width(DEPTH);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AF   = LW'(AF_THRESH);
    localparam logic [OVF_CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam bit OVERWRITE = (OVERFLOW_MODE == OVF_OVERWRITE_OLD);

    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]            level_q, level_d;
    logic                     almost_full_q, almost_full_d;
    logic                     ovf_pulse_q, ovf_pulse_d;
    logic [OVF_CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;

    logic full;
    logic push;
    logic pop;
    logic overwrite;
    logic lost;
    logic mem_we;

    assign full      = (level_q == LVL_FULL);
    assign out_valid = (level_q != '0);
    assign in_ready  = OVERWRITE ? 1'b1 : (!full || out_ready);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Flush wins over both handshakes; a flushed push is discarded, not lost.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        mem_we    = 1'b0;
        overwrite = 1'b0;
        lost      = 1'b0;
        ovf_cnt_d = clr_ovf ? '0 : ovf_cnt_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            mem_we = push;
            // Only reachable in overwrite mode: a full drop-mode FIFO accepts only alongside a pop.
            overwrite = push && full && !pop;
            lost      = OVERWRITE ? overwrite : (in_valid && !in_ready);
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop || overwrite) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop && !full) begin
                level_d = level_q + LW'(1);
            end else if (pop && !push) begin
                level_d = level_q - LW'(1);
            end
        end

        if (lost && (ovf_cnt_d != CNT_MAX)) begin
            ovf_cnt_d = ovf_cnt_d + OVF_CNT_WIDTH'(1);
        end

        almost_full_d = (level_d >= LVL_AF);
        ovf_pulse_d   = lost;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            almost_full_q <= 1'b0;
            ovf_pulse_q   <= 1'b0;
            ovf_cnt_q     <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            almost_full_q <= almost_full_d;
            ovf_pulse_q   <= ovf_pulse_d;
            ovf_cnt_q     <= ovf_cnt_d;
        end
    end

    trace_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (PW)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (out_data)
    );

    assign level          = level_q;
    assign almost_full    = almost_full_q;
    assign overflow_count = ovf_cnt_q;
    assign ovf_pulse      = ovf_pulse_q;

endmodule

// File: tb/tb_trace_fifo.sv
// Scoreboard bench: one drop-mode and one overwrite-mode FIFO share stimulus,
// each checked against its own queue-based reference model.
module tb_trace_fifo;
    import trace_buffer_pkg::*;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AF    = 2;
    localparam int unsigned CW    = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;
    localparam int          CMAX  = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          flush;
    logic          clr_ovf;

    logic          o_in_ready [2];
    logic          o_valid    [2];
    logic [DW-1:0] o_data     [2];
    logic [LW-1:0] o_level    [2];
    logic          o_af       [2];
    logic [CW-1:0] o_cnt      [2];
    logic          o_pulse    [2];

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    trace_fifo #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .OVERFLOW_MODE(OVF_DROP_NEW),
        .AF_THRESH(AF), .OVF_CNT_WIDTH(CW)
    ) u_drop (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_in_ready[0]),
        .in_data(in_data), .out_valid(o_valid[0]), .out_ready(out_ready),
        .out_data(o_data[0]), .flush(flush), .clr_ovf(clr_ovf), .level(o_level[0]),
        .almost_full(o_af[0]), .overflow_count(o_cnt[0]), .ovf_pulse(o_pulse[0])
    );

    trace_fifo #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .OVERFLOW_MODE(OVF_OVERWRITE_OLD),
        .AF_THRESH(AF), .OVF_CNT_WIDTH(CW)
    ) u_ovw (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_in_ready[1]),
        .in_data(in_data), .out_valid(o_valid[1]), .out_ready(out_ready),
        .out_data(o_data[1]), .flush(flush), .clr_ovf(clr_ovf), .level(o_level[1]),
        .almost_full(o_af[1]), .overflow_count(o_cnt[1]), .ovf_pulse(o_pulse[1])
    );

    task automatic check(input string name, input int inst,
                         input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h @%0t", name, inst, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_sb
        localparam bit OVW = (g == 1);
        logic [DW-1:0] exp_q [$];
        int m_level;
        int m_cnt;
        bit m_pulse;

        // Reference model: queue contents plus loss accounting, updated per edge.
        initial begin : model
            bit full, rdy, pu, po, lost;
            logic [DW-1:0] dropped;
            m_level = 0;
            m_cnt   = 0;
            m_pulse = 0;
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    exp_q.delete();
                    m_level = 0;
                    m_cnt   = 0;
                    m_pulse = 0;
                end else begin
                    full = (m_level == int'(DEPTH));
                    rdy  = OVW || !full || out_ready;
                    pu   = in_valid && rdy;
                    po   = (m_level != 0) && out_ready;
                    lost = 0;
                    if (clr_ovf) m_cnt = 0;
                    if (flush) begin
                        exp_q.delete();
                        m_level = 0;
                    end else begin
                        lost = OVW ? (pu && full && !po) : (in_valid && !rdy);
                        if (pu) exp_q.push_back(in_data);
                        if (OVW && lost) dropped = exp_q.pop_front();
                        if (pu && !po && !full) m_level++;
                        else if (po && !pu) m_level--;
                    end
                    if (lost && m_cnt < CMAX) m_cnt++;
                    m_pulse = lost;
                end
            end
        end

        // Monitor: compares status each cycle, pops the scoreboard on a handshake.
        initial begin : monitor
            logic [DW-1:0] exp_d;
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    check("level", g, 64'(o_level[g]), 64'(m_level));
                    check("out_valid", g, 64'(o_valid[g]), 64'(m_level != 0));
                    check("almost_full", g, 64'(o_af[g]), 64'(m_level >= int'(AF)));
                    check("overflow_count", g, 64'(o_cnt[g]), 64'(m_cnt));
                    check("ovf_pulse", g, 64'(o_pulse[g]), 64'(m_pulse));
                    check("in_ready", g, 64'(o_in_ready[g]),
                          64'(OVW || (m_level != int'(DEPTH)) || out_ready));
                    if (o_valid[g]) begin
                        if (exp_q.size() == 0) begin
                            check("out_data_unexpected", g, 64'(o_valid[g]), 64'(0));
                        end else begin
                            if (out_ready) exp_d = exp_q.pop_front();
                            else exp_d = exp_q[0];
                            check("out_data", g, 64'(o_data[g]), 64'(exp_d));
                        end
                    end
                end
            end
        end
    end

    task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic ordy,
                       input logic fl, input logic clr);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        clr_ovf   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        for (int i = 0; i < 2; i++) begin
            check("rst_level", i, 64'(o_level[i]), 64'(0));
            check("rst_out_valid", i, 64'(o_valid[i]), 64'(0));
            check("rst_almost_full", i, 64'(o_af[i]), 64'(0));
            check("rst_overflow_count", i, 64'(o_cnt[i]), 64'(0));
            check("rst_ovf_pulse", i, 64'(o_pulse[i]), 64'(0));
            check("rst_out_data", i, 64'(o_data[i]), 64'(0));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        clr_ovf   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;

        // Push A,B,C without popping.
        cyc(1, 16'h00A1, 0, 0, 0);
        cyc(1, 16'h00B2, 0, 0, 0);
        check("af_after_2", 0, 64'(o_af[0]), 64'(1));
        cyc(1, 16'h00C3, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            check("level_abc", i, 64'(o_level[i]), 64'(3));
            check("head_abc", i, 64'(o_data[i]), 64'(16'h00A1));
        end

        // Fill, then three pushes against a full FIFO.
        cyc(1, 16'h00D4, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 16'h0E00 + DW'(k), 0, 0, 0);
            check("pulse_burst", 0, 64'(o_pulse[0]), 64'(1));
        end
        for (int i = 0; i < 2; i++) check("cnt_three", i, 64'(o_cnt[i]), 64'(3));
        check("head_drop", 0, 64'(o_data[0]), 64'(16'h00A1));
        check("head_ovw", 1, 64'(o_data[1]), 64'(16'h00D4));
        repeat (5) cyc(0, '0, 1, 0, 0);

        // Clear coinciding with a loss yields 1.
        for (int k = 0; k < 4; k++) cyc(1, 16'h1000 + DW'(k), 0, 0, 0);
        cyc(1, 16'h1FFF, 0, 0, 1);
        for (int i = 0; i < 2; i++) check("clr_with_loss", i, 64'(o_cnt[i]), 64'(1));

        // Full with simultaneous push and pop across pointer wrap.
        for (int k = 0; k < 10; k++) cyc(1, 16'h2000 + DW'(k), 1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            check("full_pp_level", i, 64'(o_level[i]), 64'(4));
            check("full_pp_cnt", i, 64'(o_cnt[i]), 64'(1));
        end

        // Flush at level 3 together with push and pop.
        repeat (5) cyc(0, '0, 1, 0, 0);
        for (int k = 0; k < 3; k++) cyc(1, 16'h3000 + DW'(k), 0, 0, 0);
        cyc(1, 16'h3FFF, 1, 1, 0);
        for (int i = 0; i < 2; i++) begin
            check("flush_level", i, 64'(o_level[i]), 64'(0));
            check("flush_cnt", i, 64'(o_cnt[i]), 64'(1));
        end
        cyc(1, 16'h4321, 0, 0, 0);
        for (int i = 0; i < 2; i++) check("post_flush_head", i, 64'(o_data[i]), 64'(16'h4321));

        // Asynchronous reset mid-stream at level 2.
        cyc(1, 16'h4322, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        #1;
        rst_n = 1'b1;

        // Randomised traffic.
        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom_range(0, 9) < 7), DW'($urandom), $urandom_range(0, 1) == 1,
                $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
        end

        repeat (6) cyc(0, '0, 1, 0, 0);
        for (int i = 0; i < 2; i++) check("drained", i, 64'(o_level[i]), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/trace_fifo.md
Name: trace_fifo

Overview:
- Parametrised successor to the single-entry-pop trace buffer.
- Sits between the trace generator and the trace consumer (packetiser/DMA). It stores trace elements in a circular buffer with valid/ready handshakes on both sides.
- Generalised in data width, depth and overflow policy. Adds occupancy/almost-full reporting, synchronous flush and a saturating overflow counter.
- The trace source cannot stall, so lost elements are counted rather than silently dropped.

Parameters:
- DATA_WIDTH, 64: width of one trace element in bits.
- DEPTH, 8: number of entries. Power of two, minimum 2.
- OVERFLOW_MODE, OVF_DROP_NEW: a trace_buffer_pkg::overflow_mode_e value, OVF_DROP_NEW or OVF_OVERWRITE_OLD.
- AF_THRESH, DEPTH-2: almost_full asserts when level >= AF_THRESH.
- OVF_CNT_WIDTH, 16: width of overflow_count.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer has an element this cycle.
- in_ready  out  1  element will be accepted this cycle.
- in_data  in  DATA_WIDTH  trace element in.
- out_valid  out  1  out_data holds the oldest stored element.
- out_ready  in  1  consumer takes out_data this cycle.
- out_data  out  DATA_WIDTH  oldest element (show-ahead).
- flush  in  1  synchronous discard of all stored entries.
- clr_ovf  in  1  synchronous clear of overflow_count.
- level  out  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- almost_full  out  1  level >= AF_THRESH.
- overflow_count  out  OVF_CNT_WIDTH  elements lost since reset/clr_ovf; saturating.
- ovf_pulse  out  1  one-cycle strobe on each lost element.

Behaviour:
- Reset (rst_n=0, asynchronous): the following are all 0:
  - wr_ptr, rd_ptr, level
  - out_valid, almost_full, overflow_count, ovf_pulse
  - storage contents
  - Reset mid-transfer discards everything. First accept is possible in the first cycle after deassertion.
- Handshakes:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
  - Both are evaluated on the same edge.
- in_ready is combinational from registered state:
  - OVF_DROP_NEW: in_ready = (level != DEPTH) || out_ready.
  - OVF_OVERWRITE_OLD: in_ready = 1.
- out_valid = (level != 0), registered-state derived. out_data = mem[rd_ptr].
- Latency: an element pushed at edge N is visible on out_data with out_valid=1 after edge N; it can be popped at edge N+1.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
  - level is tracked separately so that full (DEPTH) and empty (0) are distinct.
- Level update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, including when full or when level==1.
- Full in OVF_DROP_NEW mode:
  - When in_valid=1 and in_ready=0, the element is lost.
  - overflow_count increments and ovf_pulse=1 on the next cycle.
  - Storage is unchanged.
- Full in OVF_OVERWRITE_OLD mode:
  - When push=1 and pop=0, mem[wr_ptr] is overwritten (it aliases rd_ptr).
  - Both pointers advance; level stays DEPTH.
  - overflow_count increments and ovf_pulse=1.
- overflow_count saturates at all-ones and does not wrap.
- clr_ovf:
  - Zeroes overflow_count next edge.
  - If a loss occurs in the same cycle, the result is 1 (clear first, then increment).
  - ovf_pulse is still asserted.
- flush has priority over push and pop in the same cycle:
  - wr_ptr, rd_ptr and level go to 0. Storage is not cleared.
  - A push coinciding with flush is discarded and not counted as overflow.
  - A pop coinciding with flush is still considered taken by the consumer. out_data was valid that cycle.
- almost_full is registered from the next-state level, so it is coherent with level.
- ovf_pulse is registered and high for exactly one cycle per lost element. It is high on consecutive cycles for back-to-back losses.
- Empty with pop attempted: impossible, since out_valid=0; out_ready is ignored.
- There is no state machine beyond the pointer/level datapath, so no illegal states exist.

Decomposition:
- trace_buffer_pkg holds:
  - overflow_mode_e enum (OVF_DROP_NEW, OVF_OVERWRITE_OLD)
  - trace element typedef, default DATA_WIDTH=64
  - level_t/ptr_t width helper functions
- Sub-module trace_fifo_mem: DEPTH x DATA_WIDTH register array with 1 write and 1 asynchronous read port, reset to zero. The control logic lives in trace_fifo.

Test Plan (DEPTH=4, AF_THRESH=2):
- Reset, then push A,B,C on consecutive cycles with out_ready=0 → level 1,2,3; almost_full=1 after the 2nd push; out_data=A throughout.
- DROP mode, fill to 4, then in_valid=1 for 3 cycles with out_ready=0 → in_ready=0; overflow_count=3; ovf_pulse high 3 cycles; pops return the original 4 in order.
- OVERWRITE mode, push E0..E5 with out_ready=0 → level=4, overflow_count=2, pops yield E2,E3,E4,E5.
- Full, push and pop together for 10 cycles (both modes) → level stays 4; no overflow; ordering preserved across pointer wrap.
- level=3, assert flush together with push and pop → level=0, out_valid=0 next cycle, overflow_count unchanged; next push appears after 1 cycle.
- Assert rst_n=0 mid-stream at level=2 with overflow_count=5 → all outputs 0 immediately (asynchronous); clr_ovf in the same cycle as a loss gives overflow_count=1.
